serial_add_seq: RTL and testbench

- Bit-serial add/subtract sequencer that time-shares a single 1-bit full-adder cell across a WIDTH-bit operation.
- Operands are accepted through a valid/ready handshake and processed LSB-first, one bit per clock.
- The result is presented through an output valid/ready handshake.
- Sits between the pin-level I/O wrapper and the adder cell. It replaces a WIDTH-bit parallel adder in area-limited tiles.

---
 rtl/serial_add_pkg.sv | 7 +
 rtl/full_adder_bit.sv | 17 +
 rtl/serial_add_seq.sv | 86 ++++++++
 tb/tb_serial_add_seq.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared states, default width and op encodings for the bit-serial adder
package serial_add_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam int DEFAULT_WIDTH = 8;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/full_adder_bit.sv
// full_adder_bit: single-bit full adder built from two half-adder stages
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic h, c1, c2;
  always_comb begin
    h    = a ^ b;
    c1   = a & b;
    s    = h ^ cin;
    c2   = h & cin;
    cout = c1 | c2;
  end
endmodule

// File: rtl/serial_add_seq.sv
// serial_add_seq: LSB-first bit-serial add/subtract sequencer sharing one full-adder cell
module serial_add_seq
  import serial_add_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic             s, c_nxt;

  full_adder_bit u_fa (.a(a_q[0]), .b(b_q[0]), .cin(carry_q), .s(s), .cout(c_nxt));

  // subtraction is A + ~B + 1, so the inverted operand and carry-in are set at accept
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    if (state_q == IDLE && in_valid) begin
      state_d = RUN;
      a_d     = op_a;
      b_d     = (op_sub == OP_SUB) ? ~op_b : op_b;
      carry_d = op_sub;
      cnt_d   = '0;
    end else if (state_q == RUN) begin
      a_d     = a_q >> 1;
      b_d     = b_q >> 1;
      res_d   = (res_q >> 1) | (WIDTH'(s) << (WIDTH - 1));
      carry_d = c_nxt;
      cnt_d   = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(WIDTH - 1)) begin
        state_d = DONE;
        cout_d  = c_nxt;
      end
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    in_ready  = state_q == IDLE;
    out_valid = state_q == DONE;
    busy      = state_q != IDLE;
    sum       = res_q;
    cout      = cout_q;
  end
endmodule

// File: tb/tb_serial_add_seq.sv
// tb_serial_add_seq: directed checks of the bit-serial adder at WIDTH=8
module tb_serial_add_seq;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       in_valid = 1'b0, op_sub = 1'b0, out_ready = 1'b0;
  logic [7:0] op_a = '0, op_b = '0, sum;
  logic       in_ready, out_valid, cout, busy;
  int         total = 0, bad = 0;

  serial_add_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_sub(op_sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) if (rst_n) chk("rdy_vld_excl", {31'd0, in_ready & out_valid}, 32'd0);

  task automatic wait_done(input string tag);
    int lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) break;
    end
    chk({tag, "_lat"}, lat, 8);
  endtask

  task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic sub, input logic [7:0] es, input logic ec);
    @(negedge clk);
    op_a = a; op_b = b; op_sub = sub; in_valid = 1'b1; out_ready = 1'b1;
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_done(tag);
    chk({tag, "_sum"}, {24'd0, sum}, {24'd0, es});
    chk({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    chk({tag, "_idle"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [7:0] ta [3], tb [3], es [3];
    logic       tsub [3], ec [3];
    int         acc [3];
    int         cyc, n, r;
    #2;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sum", {24'd0, sum}, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    do_op("add", 8'h5A, 8'h25, 1'b0, 8'h7F, 1'b0);
    do_op("wrap1", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    do_op("wrap2", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
    do_op("sub1", 8'h10, 8'h01, 1'b1, 8'h0F, 1'b1);
    do_op("sub2", 8'h00, 8'h01, 1'b1, 8'hFF, 1'b0);

    // backpressure with stray in_valid during RUN and DONE
    @(negedge clk);
    op_a = 8'hF0; op_b = 8'h20; op_sub = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1 op_a = 8'h11; op_b = 8'h11; op_sub = 1'b1;
    wait_done("bp");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_sum", {24'd0, sum}, 32'h10);
      chk("bp_cout", {31'd0, cout}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("bp_release_idle", {31'd0, in_ready}, 32'd1);
    chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_sum_hold", {24'd0, sum}, 32'h10);

    // asynchronous reset in the middle of RUN
    @(negedge clk);
    op_a = 8'h12; op_b = 8'h34; op_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mr_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mr_busy", {31'd0, busy}, 32'd0);
    chk("mr_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mr_sum", {24'd0, sum}, 32'd0);
    chk("mr_cout", {31'd0, cout}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    do_op("post_rst", 8'h03, 8'h04, 1'b0, 8'h07, 1'b0);

    // streaming throughput
    ta = '{8'h01, 8'h40, 8'hC8}; tb = '{8'h02, 8'h41, 8'h64}; tsub = '{1'b0, 1'b1, 1'b0};
    es = '{8'h03, 8'hFF, 8'h2C}; ec = '{1'b0, 1'b0, 1'b1};
    cyc = 0; n = 0; r = 0;
    in_valid = 1'b1; out_ready = 1'b1;
    while (r < 3 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        chk("tp_sum", {24'd0, sum}, {24'd0, es[r]});
        chk("tp_cout", {31'd0, cout}, {31'd0, ec[r]});
        r++;
      end
      if (in_ready && n < 3) begin
        op_a = ta[n]; op_b = tb[n]; op_sub = tsub[n]; in_valid = 1'b1;
        acc[n] = cyc;
        n++;
      end else in_valid = (n < 3);
    end
    chk("tp_results", r, 3);
    chk("tp_ii1", acc[1] - acc[0], 10);
    chk("tp_ii2", acc[2] - acc[1], 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end
endmodule
